// File: rtl/mult_seq.sv
// Shift-and-add multiplier driving an external addsub ALU: one ALU op per cycle, 3*L_DATA+popcount(b)+1 cycles to done.
// start is only accepted in IDLE and is never queued; EARLY_EXIT_EN ends the loop once the multiplier is exhausted.
module mult_seq #(
  parameter int L_DATA = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [L_DATA-1:0] a,
  input  logic [L_DATA-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [L_DATA-1:0] result,
  output logic              ovf,
  output logic [L_DATA-1:0] alu_op1,
  output logic [L_DATA-1:0] alu_op2,
  output logic [2:0]        alu_ctrl,
  input  logic [L_DATA-1:0] alu_out
);

  localparam int CW = (L_DATA > 1) ? $clog2(L_DATA) : 1;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [L_DATA-1:0] mcand_q, mcand_d;
  logic [L_DATA-1:0] mplr_q, mplr_d;
  logic [L_DATA-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_r_q, ovf_r_d;
  logic [L_DATA-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_r_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_r_q  <= ovf_r_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_r_d  = ovf_r_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy     = 1'b1;
    done     = 1'b0;
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = ALU_IDLE;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          mcand_d = a;
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_r_d = 1'b0;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
`ifdef EARLY_EXIT_EN
        if (mplr_q == '0)    state_d = S_DONE;
        else if (mplr_q[0])  state_d = S_ADD;
        else                 state_d = S_SHL;
`else
        if (mplr_q[0]) state_d = S_ADD;
        else           state_d = S_SHL;
`endif
      end
      S_ADD: begin
        alu_op1  = acc_q;
        alu_op2  = mcand_q;
        alu_ctrl = ALU_ADD;
        acc_d    = alu_out;
        // a sum smaller than the old accumulator means the add carried out
        if (alu_out < acc_q) ovf_r_d = 1'b1;
        state_d  = S_SHL;
      end
      S_SHL: begin
        alu_op1  = mcand_q;
        alu_op2  = L_DATA'(1);
        alu_ctrl = ALU_SHL;
        mcand_d  = alu_out;
        // a multiplicand bit lost off the top still has multiplier bits left to weight it
        if (mcand_q[L_DATA-1] && ((mplr_q >> 1) != '0)) ovf_r_d = 1'b1;
        state_d  = S_SHR;
      end
      S_SHR: begin
        alu_op1  = mplr_q;
        alu_op2  = L_DATA'(1);
        alu_ctrl = ALU_SHR;
        mplr_d   = alu_out;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(L_DATA - 1)) state_d = S_DONE;
        else                          state_d = S_TEST;
      end
      S_DONE: begin
        done     = 1'b1;
        result_d = acc_q;
        ovf_d    = ovf_r_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq with a behavioural addsub ALU closing the loop.
module tb_mult_seq;

  localparam int L = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [L-1:0] a, b;
  logic         busy, done, ovf;
  logic [L-1:0] result, alu_op1, alu_op2, alu_out;
  logic [2:0]   alu_ctrl;

  int n_vec = 0;
  int n_err = 0;

  mult_seq #(.L_DATA(L)) dut (
    .clock(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      3'b001:  alu_out = alu_op1 + alu_op2;
      3'b100:  alu_out = alu_op1 << alu_op2;
      3'b101:  alu_out = alu_op1 >> alu_op2;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [L-1:0] mb);
    int k = 0;
    int len = 0;
    for (int i = 0; i < L; i++) begin
      if (mb[i]) begin
        k++;
        len = i + 1;
      end
    end
`ifdef EARLY_EXIT_EN
    return 3 * len + k + 2;
`else
    return 3 * L + k + 1;
`endif
  endfunction

  task automatic accept(input logic [L-1:0] ta, input logic [L-1:0] tb);
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = L'($urandom);
    b = L'($urandom);
  endtask

  task automatic run(input string tag, input logic [L-1:0] ta, input logic [L-1:0] tb);
    logic [31:0]  prod;
    logic [31:0]  mask;
    int           cyc;
    int           shrs;
    prod = 32'(ta) * 32'(tb);
    mask = '0;
    shrs = 0;
    accept(ta, tb);
    cyc = 1;
    check({tag, " busy_c1"}, 32'(busy), 32'd1);
    while (!done && cyc < 200) begin
      if (alu_ctrl == 3'b001) mask = mask | (32'd1 << shrs);
      if (alu_ctrl == 3'b101) shrs++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " done_cycle"}, 32'(cyc), 32'(exp_latency(tb)));
    check({tag, " add_iters"}, mask, 32'(tb));
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " result"}, 32'(result), {16'd0, prod[15:0]});
    check({tag, " ovf"}, 32'(ovf), 32'(prod[31:16] != 16'd0));
  endtask

  initial begin : stim
    int cyc;
    int dones;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst op1", 32'(alu_op1), 32'd0);
    check("rst op2", 32'(alu_op2), 32'd0);
    check("rst ctrl", 32'(alu_ctrl), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run("3x5", 16'd3, 16'd5);
    repeat (4) @(posedge clk);
    #1;
    check("3x5 held", 32'(result), 32'd15);
    check("idle ctrl", 32'(alu_ctrl), 32'd0);
    run("ff_x_101", 16'h00FF, 16'h0101);
    run("ffff_sq", 16'hFFFF, 16'hFFFF);
    run("100_sq", 16'h0100, 16'h0100);
    run("7x0", 16'd7, 16'd0);
    run("0x9", 16'd0, 16'd9);

    // second request while busy must be dropped
    accept(16'd2, 16'd3);
    dones = 0;
    for (int i = 1; i < 150; i++) begin
      if (i == 3) begin
        a = 16'd9;
        b = 16'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("busy_drop dones", 32'(dones), 32'd1);
    check("busy_drop result", 32'(result), 32'd6);
    check("busy_drop ovf", 32'(ovf), 32'd0);

    // reset in cycle 10 of 3x5
    accept(16'd3, 16'd5);
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("midrst busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst ctrl", 32'(alu_ctrl), 32'd0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) dones++;
      @(posedge clk);
      #1;
    end
    check("midrst no_done", 32'(dones), 32'd0);
    run("2x2", 16'd2, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
